// File: rtl/smvm_stream_if.sv
// Stream bundle for smvm_stream: input word channel, result channel and sticky error flag.
interface smvm_stream_if #(
  parameter int VAL_W = 8,
  parameter int COL_W = 7,
  parameter int ACC_W = 20
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [VAL_W-1:0] val_in;
  logic [COL_W-1:0]        col_in;
  logic                    row_end;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] data_out;
  logic                    out_last;
  logic                    err;

  modport slave (
    input  in_valid, val_in, col_in, row_end, out_ready,
    output in_ready, out_valid, data_out, out_last, err
  );

  modport master (
    output in_valid, val_in, col_in, row_end, out_ready,
    input  in_ready, out_valid, data_out, out_last, err
  );
endinterface

// File: rtl/smvm_stream.sv
// Streaming CSR sparse-matrix x dense-vector engine with output FIFO.
// Optional macro SMVM_SAT_EN: saturating accumulator instead of two's-complement wrap.
//
// state    | meaning
// HDR_COLS | waiting for column-count header, clears err
// HDR_ROWS | waiting for row-count header
// VEC      | loading dense vector elements 0..cols-1
// ENT      | consuming nonzeros, in_ready throttled by FIFO space
// DRAIN    | input closed until the multiply stage is empty
module smvm_stream #(
  parameter int VAL_W     = 8,
  parameter int COL_W     = 7,
  parameter int ACC_W     = 20,
  parameter int OUT_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  smvm_stream_if.slave bus
);

  localparam int MAX_COLS = 2 ** COL_W;
  localparam int PROD_W   = 2 * VAL_W;
  localparam int PTR_W    = $clog2(OUT_DEPTH);
  localparam int CNT_W    = $clog2(OUT_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(OUT_DEPTH);

  typedef enum logic [2:0] {
    HDR_COLS,
    HDR_ROWS,
    VEC,
    ENT,
    DRAIN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [COL_W:0]          r_cols;
  logic [COL_W:0]          r_rows;
  logic [COL_W-1:0]        r_idx;
  logic [COL_W-1:0]        r_row_cnt;
  logic                    r_err;
  logic signed [VAL_W-1:0] r_vec [MAX_COLS];

  logic                     r_s1_vld;
  logic                     r_s1_end;
  logic                     r_s1_last;
  logic signed [PROD_W-1:0] r_s1_prod;
  logic signed [ACC_W-1:0]  r_acc;

  logic signed [ACC_W-1:0] r_mem_data [OUT_DEPTH];
  logic                    r_mem_last [OUT_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_last_row;
  logic                     w_col_bad;
  logic signed [VAL_W-1:0]  w_vec_rd;
  logic signed [PROD_W-1:0] w_mul;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_out_valid;
  logic [CNT_W:0]           w_occ;

  // Occupancy counts the row result still sitting in S1 so an accepted row_end always has a slot.
  assign w_push      = r_s1_vld & r_s1_end;
  assign w_occ       = {1'b0, r_count} + (CNT_W + 1)'(w_push);
  assign w_out_valid = (r_count != '0);
  assign w_pop       = w_out_valid & bus.out_ready;

  assign w_in_ready = (r_state == ENT) ? (w_occ < DEPTH_C) : (r_state != DRAIN);
  assign w_accept   = bus.in_valid & w_in_ready;

  assign w_last_row = ({1'b0, r_row_cnt} == (r_rows - 1'b1));
  assign w_col_bad  = ({1'b0, bus.col_in} >= r_cols);
  assign w_vec_rd   = r_vec[bus.col_in];
  assign w_mul      = PROD_W'(bus.val_in) * PROD_W'(w_vec_rd);
  assign w_prod_ext = ACC_W'(r_s1_prod);

`ifdef SMVM_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
  logic [ACC_W:0] w_wide;

  // One guard bit: the top two bits disagree exactly when the signed add overflowed.
  assign w_wide = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
  assign w_sum  = (w_wide[ACC_W] != w_wide[ACC_W-1]) ?
                  (w_wide[ACC_W] ? ACC_MIN : ACC_MAX) : w_wide[ACC_W-1:0];
`else
  assign w_sum = r_acc + w_prod_ext;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= HDR_COLS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HDR_COLS: if (w_accept) w_state_nxt = HDR_ROWS;
      HDR_ROWS: if (w_accept) w_state_nxt = VEC;
      VEC:      if (w_accept && ({1'b0, r_idx} == (r_cols - 1'b1))) w_state_nxt = ENT;
      ENT:      if (w_accept && bus.row_end && w_last_row) w_state_nxt = DRAIN;
      DRAIN:    if (!r_s1_vld) w_state_nxt = HDR_COLS;
      default:  w_state_nxt = HDR_COLS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cols    <= '0;
      r_rows    <= '0;
      r_idx     <= '0;
      r_row_cnt <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      case (r_state)
        HDR_COLS: begin
          r_cols    <= {1'b0, bus.col_in} + 1'b1;
          r_err     <= 1'b0;
          r_idx     <= '0;
          r_row_cnt <= '0;
        end
        HDR_ROWS: r_rows <= {1'b0, bus.col_in} + 1'b1;
        VEC:      r_idx  <= r_idx + 1'b1;
        ENT: begin
          if (w_col_bad) r_err <= 1'b1;
          if (bus.row_end) r_row_cnt <= r_row_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_accept && (r_state == VEC)) begin
      r_vec[r_idx] <= bus.val_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_end  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_prod <= '0;
      r_acc     <= '0;
    end else begin
      r_s1_vld  <= w_accept && (r_state == ENT);
      r_s1_end  <= bus.row_end;
      r_s1_last <= w_last_row;
      r_s1_prod <= w_col_bad ? '0 : w_mul;
      if (r_s1_vld) begin
        r_acc <= r_s1_end ? '0 : w_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wr_ptr] <= w_sum;
        r_mem_last[r_wr_ptr] <= r_s1_last;
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.data_out  = w_out_valid ? r_mem_data[r_rd_ptr] : '0;
  assign bus.out_last  = w_out_valid ? r_mem_last[r_rd_ptr] : 1'b0;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_smvm_stream.sv
// Scoreboard bench for smvm_stream: a software model predicts each row result when its row_end word is driven.
module tb_smvm_stream;
  localparam int VAL_W     = 8;
  localparam int COL_W     = 3;
  localparam int ACC_W     = 16;
  localparam int OUT_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  smvm_stream_if #(.VAL_W(VAL_W), .COL_W(COL_W), .ACC_W(ACC_W)) bus ();

  smvm_stream #(
    .VAL_W(VAL_W), .COL_W(COL_W), .ACC_W(ACC_W), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    longint data;
    bit     last;
  } exp_t;

  exp_t   sb[$];
  int     pop_cyc[$];
  int     n_chk = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     acc_cyc = 0;
  int     n_acc = 0;

  int     m_cols, m_rows, m_row;
  int     m_vec[8];
  longint m_acc;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint acc_add(input longint a, input longint b);
    longint s;
    logic signed [ACC_W-1:0] t;
    s = a + b;
`ifdef SMVM_SAT_EN
    if (s > (longint'(1) << (ACC_W - 1)) - 1) s = (longint'(1) << (ACC_W - 1)) - 1;
    if (s < -(longint'(1) << (ACC_W - 1))) s = -(longint'(1) << (ACC_W - 1));
    return s;
`else
    t = s[ACC_W-1:0];
    return longint'(t);
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", $signed(bus.data_out), 0);
      end else begin
        e = sb.pop_front();
        chk("data_out", $signed(bus.data_out), e.data);
        chk("out_last", bus.out_last, e.last);
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic send(input int v, input int c, input bit e);
    int waited = 0;
    bit got = 0;
    bus.in_valid = 1'b1;
    bus.val_in   = VAL_W'(v);
    bus.col_in   = COL_W'(c);
    bus.row_end  = e;
    while (!got && waited < 200) begin
      @(negedge clk);
      got = bus.in_ready;
      if (got) acc_cyc = cyc;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.in_valid = 1'b0;
    bus.row_end  = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
    else n_acc++;
  endtask

  task automatic hdr(input int cols, input int rows);
    send(0, cols - 1, 1'b0);
    m_cols = cols;
    send(0, rows - 1, 1'b0);
    m_rows = rows;
    m_row  = 0;
    m_acc  = 0;
  endtask

  task automatic vecw(input int i, input int v);
    m_vec[i] = v;
    send(v, 0, 1'b0);
  endtask

  task automatic ent(input int v, input int c, input bit e);
    longint p;
    exp_t x;
    p = (c >= m_cols) ? 0 : longint'(v) * longint'(m_vec[c]);
    m_acc = acc_add(m_acc, p);
    if (e) begin
      x.data = m_acc;
      x.last = (m_row == m_rows - 1);
      sb.push_back(x);
      m_acc = 0;
      m_row++;
    end
    send(v, c, e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic run_t1();
    hdr(2, 2);
    vecw(0, 3);
    vecw(1, -2);
    ent(4, 0, 1'b0);
    ent(1, 1, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stim
    int t_end;
    int base;
    bus.in_valid  = 1'b0;
    bus.val_in    = '0;
    bus.col_in    = '0;
    bus.row_end   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_data_out", $signed(bus.data_out), 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_err", bus.err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // T1 basic with latency checks
    bus.out_ready = 1'b1;
    pop_cyc.delete();
    run_t1();
    t_end = acc_cyc;
    ent(7, 0, 1'b1);
    wait_drain(50);
    chk("t1_pops", pop_cyc.size(), 2);
    if (pop_cyc.size() == 2) begin
      chk("t1_latency", pop_cyc[0] - t_end, 2);
      chk("t1_spacing", pop_cyc[1] - pop_cyc[0], 1);
    end
    chk("t1_err", bus.err, 0);

    // T2 empty row
    hdr(2, 3);
    vecw(0, 3);
    vecw(1, -2);
    ent(5, 0, 1'b1);
    ent(0, 0, 1'b1);
    ent(-1, 1, 1'b1);
    wait_drain(50);

    // T3 backpressure
    bus.out_ready = 1'b0;
    hdr(2, 6);
    vecw(0, 3);
    vecw(1, -2);
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) ent(i + 1, i % 2, 1'b1);
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("t3_ready_low", bus.in_ready, 0);
        chk("t3_accepted", n_acc - base, 4);
        chk("t3_fifo_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain(80);

    // T4 accumulator overflow
    hdr(1, 1);
    vecw(0, -128);
    ent(-128, 0, 1'b0);
    ent(-128, 0, 1'b0);
    ent(-128, 0, 1'b1);
    wait_drain(50);

    // T5 bad column index, cleared by the next header
    hdr(2, 1);
    vecw(0, 3);
    vecw(1, -2);
    ent(9, 5, 1'b1);
    wait_drain(50);
    chk("t5_err_set", bus.err, 1);
    send(0, 1, 1'b0);
    m_cols = 2;
    chk("t5_err_clr", bus.err, 0);
    send(0, 0, 1'b0);
    m_rows = 1;
    m_row  = 0;
    m_acc  = 0;
    vecw(0, 3);
    vecw(1, -2);
    ent(2, 1, 1'b1);
    wait_drain(50);

    // T6 reset mid-matrix with queued results
    bus.out_ready = 1'b0;
    hdr(2, 4);
    vecw(0, 3);
    vecw(1, -2);
    ent(4, 0, 1'b1);
    ent(9, 5, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_valid", bus.out_valid, 1);
    chk("t6_pre_err", bus.err, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("t6_out_valid", bus.out_valid, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_err", bus.err, 0);
    chk("t6_data_out", $signed(bus.data_out), 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    run_t1();
    ent(7, 0, 1'b1);
    wait_drain(50);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
